// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    // Per-cycle grant decision
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CORE = 2'd1,
        GNT_EXT  = 2'd2
    } arb_gnt_e;

    // Width of the external-master starvation counter
    localparam int unsigned ARB_WAIT_W = 4;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: the core's M-stage
// port has priority, and the external master gets a forced grant once it has
// been denied MAX_WAIT consecutive cycles.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 32,
    parameter int unsigned MAX_WAIT = 4   // legal range 1..15
) (
    input  logic          clk,
    input  logic          rst,

    // Core memory-stage port
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,

    // External master port
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_gnt,
    output logic          ext_rvalid,
    output logic [DW-1:0] ext_rdata,

    // Data memory port
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [ARB_WAIT_W-1:0] MaxWait = ARB_WAIT_W'(MAX_WAIT);

    logic [ARB_WAIT_W-1:0] r_wait_cnt;
    logic [ARB_WAIT_W-1:0] w_wait_cnt_d;
    logic                  r_ext_rvalid;
    logic [DW-1:0]         r_ext_rdata;
    arb_gnt_e              w_gnt;
    logic                  w_ext_gnt;
    logic                  w_ext_rd_gnt;

    // Grant decision; reset forces NONE so nothing reaches memory while rst is low
    always_comb begin
        w_gnt = GNT_NONE;
        if (!rst) begin
            w_gnt = GNT_NONE;
        end else if (ext_req && (!core_req || (r_wait_cnt == MaxWait))) begin
            w_gnt = GNT_EXT;
        end else if (core_req) begin
            w_gnt = GNT_CORE;
        end
    end

    assign w_ext_gnt    = (w_gnt == GNT_EXT);
    assign w_ext_rd_gnt = w_ext_gnt && !ext_we;

    // Memory mux: idle cycles park the address/data on the core port
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        unique case (w_gnt)
            GNT_EXT: begin
                mem_we    = ext_we;
                mem_addr  = ext_addr;
                mem_wdata = ext_wdata;
            end
            GNT_CORE: begin
                mem_we    = core_we;
            end
            default: begin
                mem_we    = 1'b0;
            end
        endcase
    end

    // Requester-facing handshake outputs
    always_comb begin
        core_rdata = mem_rdata;
        core_stall = rst && core_req && (w_gnt != GNT_CORE);
        ext_gnt    = w_ext_gnt;
        ext_rvalid = r_ext_rvalid;
        ext_rdata  = r_ext_rdata;
    end

    // Starvation counter next state: counts denied external cycles, saturating
    always_comb begin
        w_wait_cnt_d = r_wait_cnt;
        if (!ext_req || w_ext_gnt) begin
            w_wait_cnt_d = '0;
        end else if (r_wait_cnt >= MaxWait) begin
            w_wait_cnt_d = MaxWait;
        end else begin
            w_wait_cnt_d = r_wait_cnt + 1'b1;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= w_wait_cnt_d;
        end
    end

    // External read return: capture memory data on the edge ending a read grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ext_rvalid <= 1'b0;
            r_ext_rdata  <= '0;
        end else begin
            r_ext_rvalid <= w_ext_rd_gnt;
            if (w_ext_rd_gnt) begin
                r_ext_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter with a behavioural data memory.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic        core_req;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        ext_req;
    logic        ext_we;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_gnt;
    logic        ext_rvalid;
    logic [31:0] ext_rdata;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];

    typedef struct {
        logic        exp_gnt;
        logic        exp_stall;
        logic        exp_rvalid;
        logic [31:0] exp_rdata;
        logic        chk_crd;
        logic [31:0] exp_crd;
        logic        exp_we;
        logic [31:0] exp_addr;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        pend_rd = 1'b0;
    logic [31:0] pend_data = '0;
    logic        rst_mid = 1'b0;

    dmem_arbiter #(
        .DW       (32),
        .AW       (32),
        .MAX_WAIT (4)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_gnt    (ext_gnt),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory: combinational read, write on the rising edge
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; g is the hand-derived grant, dexp the expected read data
    task automatic cyc(input logic cr, input logic cwe, input logic [31:0] caddr,
                       input logic [31:0] cwd, input logic er, input logic ewe,
                       input logic [31:0] eaddr, input logic [31:0] ewd,
                       input arb_gnt_e g, input logic [31:0] dexp);
        exp_t e;
        core_req   = cr;
        core_we    = cwe;
        core_addr  = caddr;
        core_wdata = cwd;
        ext_req    = er;
        ext_we     = ewe;
        ext_addr   = eaddr;
        ext_wdata  = ewd;
        e.exp_gnt    = (g == GNT_EXT);
        e.exp_stall  = cr && (g != GNT_CORE);
        e.exp_rvalid = pend_rd;
        e.exp_rdata  = pend_data;
        e.chk_crd    = (g == GNT_CORE) && !cwe;
        e.exp_crd    = dexp;
        e.exp_we     = (g == GNT_CORE) ? cwe : ((g == GNT_EXT) ? ewe : 1'b0);
        e.exp_addr   = (g == GNT_EXT) ? eaddr : caddr;
        sb_q.push_back(e);
        pend_rd   = (g == GNT_EXT) && !ewe;
        pend_data = dexp;
        if (rst_mid) begin
            #2;
            rst     = 1'b0;
            rst_mid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, GNT_NONE, 32'h0);
    endtask

    // Monitor: pops one expectation per cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("ext_gnt", {31'b0, ext_gnt}, {31'b0, e.exp_gnt});
            check("core_stall", {31'b0, core_stall}, {31'b0, e.exp_stall});
            check("mem_we", {31'b0, mem_we}, {31'b0, e.exp_we});
            check("mem_addr", mem_addr, e.exp_addr);
            check("ext_rvalid", {31'b0, ext_rvalid}, {31'b0, e.exp_rvalid});
            if (e.exp_rvalid) check("ext_rdata", ext_rdata, e.exp_rdata);
            if (e.chk_crd) check("core_rdata", core_rdata, e.exp_crd);
        end
    end

    initial begin
        rst        = 1'b0;
        core_req   = 1'b1;
        core_we    = 1'b1;
        core_addr  = 32'h40;
        core_wdata = 32'h0;
        ext_req    = 1'b1;
        ext_we     = 1'b1;
        ext_addr   = 32'h80;
        ext_wdata  = 32'h0;
        @(posedge clk);
        #1;
        // Reset state with both requesters active
        check("rst_mem_we", {31'b0, mem_we}, 32'h0);
        check("rst_ext_gnt", {31'b0, ext_gnt}, 32'h0);
        check("rst_core_stall", {31'b0, core_stall}, 32'h0);
        check("rst_ext_rvalid", {31'b0, ext_rvalid}, 32'h0);
        check("rst_ext_rdata", ext_rdata, 32'h0);
        core_req = 1'b0;
        ext_req  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Core only: store then load
        cyc(1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0, GNT_CORE, 32'h0);
        cyc(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, GNT_CORE, 32'hDEADBEEF);

        // Ext only: write then read, granted same cycle
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h80, 32'h12345678, GNT_EXT, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0, GNT_EXT, 32'h12345678);
        idle();

        // Contention: ext read of 0x40 granted at cycle 4
        for (int i = 0; i < 5; i++) begin
            if (i == 4)
                cyc(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, GNT_EXT, 32'hDEADBEEF);
            else
                cyc(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, GNT_CORE, 32'h12345678);
        end
        cyc(1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, GNT_CORE, 32'h12345678);

        // Sustained contention for 20 cycles: one ext grant every 5th cycle
        for (int i = 0; i < 20; i++) begin
            if ((i % 5) == 4)
                cyc(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, GNT_EXT, 32'hDEADBEEF);
            else
                cyc(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, GNT_CORE, 32'h12345678);
        end
        idle();

        // Ext write dropped at wait_cnt == 3, re-raised, granted 4 cycles later
        for (int i = 0; i < 9; i++) begin
            if (i == 3)
                cyc(1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, GNT_CORE, 32'h12345678);
            else if (i == 8)
                cyc(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 1'b1, 32'hC0, 32'hCAFEF00D, GNT_EXT, 32'h0);
            else
                cyc(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 1'b1, 32'hC0, 32'hCAFEF00D, GNT_CORE,
                    32'h12345678);
        end
        idle();
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hC0, 32'h0, GNT_EXT, 32'hCAFEF00D);
        idle();

        // Reset asserted during an ext read grant cycle: no grant, no rvalid
        rst_mid = 1'b1;
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, GNT_NONE, 32'h0);
        // Held in reset: an ext write must not reach memory
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h11111111, GNT_NONE, 32'h0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4)
                cyc(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, GNT_EXT, 32'hDEADBEEF);
            else
                cyc(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, GNT_CORE, 32'h12345678);
        end
        idle();
        idle();

        @(posedge clk);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port data memory between the RiscV core's memory-stage port and an external master (debug/loader/DMA). Sits between the core and `dmem` inside the top-level wrapper. Grants at most one access per cycle. Core has priority, with a bounded-wait starvation guard for the external master. Stalls the core whenever the core loses arbitration.

## Interface
Parameters:
- `DW`, 32, data width.
- `AW`, 32, address width. Addresses pass through unmodified.
- `MAX_WAIT`, 4, number of consecutive denied external-request cycles before the external master is forced a grant. Legal range is 1..15.

Ports (clock and reset first):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous assert, active-low.
- `core_req`  in  1  core memory access request (load or store in M stage).
- `core_we`  in  1  core access is a store.
- `core_addr`  in  AW  core address.
- `core_wdata`  in  DW  core store data.
- `core_rdata`  out  DW  core load data; combinational from `mem_rdata`.
- `core_stall`  out  1  core lost arbitration this cycle; core must hold its M-stage request stable.
- `ext_req`  in  1  external request; held until `ext_gnt`.
- `ext_we`  in  1  external access is a write.
- `ext_addr`  in  AW  external address.
- `ext_wdata`  in  DW  external write data.
- `ext_gnt`  out  1  external access performed this cycle.
- `ext_rvalid`  out  1  registered read-data valid, one cycle after a read grant.
- `ext_rdata`  out  DW  registered read data.
- `mem_we`  out  1  to `dmem` write enable.
- `mem_addr`  out  AW  to `dmem` address.
- `mem_wdata`  out  DW  to `dmem` write data.
- `mem_rdata`  in  DW  from `dmem`; combinational read.

## Operation
- Per-cycle grant (combinational), with `gnt` taking one of NONE, CORE or EXT:
  - EXT if `ext_req` and (not `core_req` or `wait_cnt == MAX_WAIT`).
  - Else CORE if `core_req`.
  - Else NONE.
- Memory mux: the granted requester drives `mem_addr`, `mem_wdata` and `mem_we`. On NONE, `mem_we` = 0 and `mem_addr`/`mem_wdata` follow the core.
- `core_stall` = `core_req` and `gnt` != CORE.
- `core_rdata` = `mem_rdata` in all cycles. It is only meaningful when `gnt` = CORE.
- `ext_gnt` = (`gnt` == EXT).
- `wait_cnt` (4-bit) register:
  - Clears when `ext_gnt` is high or `ext_req` is low.
  - Otherwise increments, saturating at `MAX_WAIT`.
- Read return: when `ext_gnt` and not `ext_we`, then next cycle `ext_rvalid` = 1 and `ext_rdata` = the granted-cycle `mem_rdata`. Otherwise `ext_rvalid` = 0 and `ext_rdata` holds its last value.
- Starvation bound: an external request waits at most `MAX_WAIT` cycles. The forced grant stalls the core for exactly one cycle. After that the counter is 0 and core priority resumes.
- Same-address collision: grants are exclusive, so there is no write conflict. Ordering is the grant order.
- Reset (`rst` low, asynchronous): `wait_cnt` = 0, `ext_rvalid` = 0, `ext_rdata` = 0. `mem_we`, `ext_gnt` and `core_stall` are forced 0 while `rst` is low. A read granted in the cycle reset asserts produces no `ext_rvalid`.

## Timing
- Core access: zero added latency when granted; store commits on the same edge.
- External write: commits on the edge ending the `ext_gnt` cycle.
- External read: data is valid 1 cycle after `ext_gnt`.
- Uncontended external request: granted in the same cycle it is raised.
- Contended external request: granted at the latest in cycle `MAX_WAIT` + 1 after it is raised (cycle 1 is the first request cycle).
- Back-to-back external requests (`ext_req` held after a grant): `wait_cnt` restarts from 0. Against continuous core traffic this gives one external grant per `MAX_WAIT` + 1 cycles.
- Combinational paths: `core_req`/`ext_req` → `mem_*`, `core_stall`, `ext_gnt`; `mem_rdata` → `core_rdata`.

## Structure
- Package `dmem_arb_pkg` holds:
  - enum `arb_gnt_e` {GNT_NONE, GNT_CORE, GNT_EXT};
  - localparam `ARB_WAIT_W` = 4.
- Single module. No sub-module is needed. The grant logic, mux, wait counter and read-return register are kept inline.

## Test plan
- Core only: store 0xDEADBEEF to 0x40, then load 0x40 → `core_stall` = 0 both cycles, load `core_rdata` = 0xDEADBEEF.
- Ext only: write 0x12345678 to 0x80, then read 0x80 → `ext_gnt` in the same cycle as each request; `ext_rvalid` = 1 with `ext_rdata` = 0x12345678 on the cycle after the read grant.
- Contention, `MAX_WAIT` = 4: core requests every cycle and ext read is raised at cycle 0 → `ext_gnt` at cycle 4, `core_stall` = 1 only at cycle 4, `ext_rvalid` at cycle 5.
- Sustained contention, ext_req held 20 cycles → exactly one `ext_gnt` per 5 cycles and no `core_stall` outside those cycles.
- Reset mid-operation: assert `rst` low in the cycle of an ext read grant → `ext_rvalid` stays 0. After release, `wait_cnt` restarts, so the first grant with the core busy occurs after 4 wait cycles.
- Ext request dropped at `wait_cnt` = 3, then re-raised → counter restarts at 0 and the grant comes 4 cycles after the re-raise.
